// File: rtl/collatz_engine.sv
// Collatz orbit engine: iterates n -> n/2 or 3n+1 once per clock from a captured
// start value, reporting orbit length, maximum iterate and a termination status.
module collatz_engine #(
  parameter int BITS      = 32,
  parameter int LEN_BITS  = 16,
  parameter int MAX_STEPS = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BITS-1:0]     number,
  output logic                busy,
  output logic                done,
  output logic [1:0]          status,
  output logic [LEN_BITS-1:0] orbit_len,
  output logic [BITS-1:0]     path_record
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0]          ST_OK      = 2'b00;
  localparam logic [1:0]          ST_OVF     = 2'b01;
  localparam logic [1:0]          ST_TIMEOUT = 2'b10;
  localparam logic [1:0]          ST_ZERO    = 2'b11;
  localparam logic [LEN_BITS-1:0] MAX_LEN    = LEN_BITS'(MAX_STEPS);
  localparam logic [LEN_BITS-1:0] LEN_ONE    = LEN_BITS'(1);
  localparam logic [BITS-1:0]     ITER_ONE   = BITS'(1);
  localparam logic [BITS+1:0]     WIDE_ONE   = (BITS+2)'(1);

  state_t                state_r, state_s;
  logic [BITS-1:0]       iter_r, iter_s;
  logic [LEN_BITS-1:0]   len_s;
  logic [BITS-1:0]       rec_s;
  logic [1:0]            status_s;
  logic                  busy_s, done_s;
  logic [BITS+1:0]       wide_s, triple_s;

  // 3n+1 is formed two bits wider so an overflow shows up in the top bits
  assign wide_s   = {2'b00, iter_r};
  assign triple_s = (wide_s << 1) + wide_s + WIDE_ONE;

  // Next-state and next-output evaluation; every register holds unless updated
  always_comb begin
    state_s  = state_r;
    iter_s   = iter_r;
    len_s    = orbit_len;
    rec_s    = path_record;
    status_s = status;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (number == {BITS{1'b0}}) begin
            done_s   = 1'b1;
            status_s = ST_ZERO;
            len_s    = {LEN_BITS{1'b0}};
            rec_s    = {BITS{1'b0}};
          end else begin
            iter_s   = number;
            rec_s    = number;
            len_s    = {LEN_BITS{1'b0}};
            status_s = ST_OK;
            busy_s   = 1'b1;
            state_s  = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        busy_s = 1'b1;
        if (abort) begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end else if (iter_r == ITER_ONE) begin
          busy_s   = 1'b0;
          done_s   = 1'b1;
          status_s = ST_OK;
          state_s  = IDLE;
        end else if (orbit_len == MAX_LEN) begin
          busy_s   = 1'b0;
          done_s   = 1'b1;
          status_s = ST_TIMEOUT;
          state_s  = IDLE;
        end else if (!iter_r[0]) begin
          iter_s = iter_r >> 1;
          len_s  = orbit_len + LEN_ONE;
        end else if (triple_s[BITS+1:BITS] != 2'b00) begin
          busy_s   = 1'b0;
          done_s   = 1'b1;
          status_s = ST_OVF;
          state_s  = IDLE;
        end else begin
          iter_s = triple_s[BITS-1:0];
          len_s  = orbit_len + LEN_ONE;
          if (triple_s[BITS-1:0] > path_record) begin
            rec_s = triple_s[BITS-1:0];
          end else begin
            rec_s = path_record;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, iterate and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      iter_r      <= {BITS{1'b0}};
      orbit_len   <= {LEN_BITS{1'b0}};
      path_record <= {BITS{1'b0}};
      status      <= 2'b00;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_s;
      iter_r      <= iter_s;
      orbit_len   <= len_s;
      path_record <= rec_s;
      status      <= status_s;
      busy        <= busy_s;
      done        <= done_s;
    end
  end

endmodule

// File: tb/tb_collatz_engine.sv
// Directed bench for collatz_engine: default, 8-bit and step-limited instances
// driven with hand-computed orbits, abort and asynchronous reset scenarios.
module tb_collatz_engine;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   sel;

  logic        a_start, a_abort, a_busy, a_done;
  logic [31:0] a_number, a_rec;
  logic [1:0]  a_status;
  logic [15:0] a_len;

  logic        b_start, b_abort, b_busy, b_done;
  logic [7:0]  b_number, b_rec;
  logic [1:0]  b_status;
  logic [15:0] b_len;

  logic        c_start, c_abort, c_busy, c_done;
  logic [31:0] c_number, c_rec;
  logic [1:0]  c_status;
  logic [15:0] c_len;

  logic        m_busy, m_done;
  logic [1:0]  m_status;
  logic [15:0] m_len;
  logic [31:0] m_rec;

  collatz_engine dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .number(a_number),
    .busy(a_busy), .done(a_done), .status(a_status), .orbit_len(a_len), .path_record(a_rec)
  );

  collatz_engine #(.BITS(8), .LEN_BITS(16), .MAX_STEPS(65535)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .number(b_number),
    .busy(b_busy), .done(b_done), .status(b_status), .orbit_len(b_len), .path_record(b_rec)
  );

  collatz_engine #(.BITS(32), .LEN_BITS(16), .MAX_STEPS(10)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort), .number(c_number),
    .busy(c_busy), .done(c_done), .status(c_status), .orbit_len(c_len), .path_record(c_rec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the selected instance onto a common set of observation signals
  always_comb begin
    m_busy = a_busy; m_done = a_done; m_status = a_status; m_len = a_len; m_rec = a_rec;
    case (sel)
      1: begin
        m_busy = b_busy; m_done = b_done; m_status = b_status; m_len = b_len;
        m_rec = {24'd0, b_rec};
      end
      2: begin
        m_busy = c_busy; m_done = c_done; m_status = c_status; m_len = c_len; m_rec = c_rec;
      end
      default: begin
        m_busy = a_busy;
      end
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v, input logic [31:0] num);
    case (s)
      1: begin b_start = v; b_number = num[7:0]; end
      2: begin c_start = v; c_number = num; end
      default: begin a_start = v; a_number = num; end
    endcase
  endtask

  // Pulse start on instance s and count edges (start edge = 1) until done
  task automatic run(input int s, input logic [31:0] num, output int edges, output int busy_cnt);
    sel = s;
    @(negedge clk);
    set_start(s, 1'b1, num);
    @(posedge clk);
    edges = 1;
    busy_cnt = 0;
    @(negedge clk);
    set_start(s, 1'b0, num);
    while (!m_done && edges < 400) begin
      if (m_busy) busy_cnt++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  int edges, bcnt, done_seen;

  initial begin
    checks = 0; errors = 0; sel = 0;
    a_start = 1'b0; a_abort = 1'b0; a_number = 32'd0;
    b_start = 1'b0; b_abort = 1'b0; b_number = 8'd0;
    c_start = 1'b0; c_abort = 1'b0; c_number = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", a_busy, 1'b0);
    check_eq("rst_done", a_done, 1'b0);
    check_eq("rst_status", a_status, 2'd0);
    check_eq("rst_len", a_len, 16'd0);
    check_eq("rst_rec", a_rec, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 32'd6, edges, bcnt);
    check_eq("n6_edges", edges, 10);
    check_eq("n6_busy", bcnt, 9);
    check_eq("n6_status", m_status, 2'b00);
    check_eq("n6_len", m_len, 16'd8);
    check_eq("n6_rec", m_rec, 32'd16);
    check_eq("n6_busy_at_done", m_busy, 1'b0);
    @(negedge clk);
    check_eq("n6_done_pulse", m_done, 1'b0);
    check_eq("n6_hold_len", m_len, 16'd8);

    run(0, 32'd27, edges, bcnt);
    check_eq("n27_edges", edges, 113);
    check_eq("n27_status", m_status, 2'b00);
    check_eq("n27_len", m_len, 16'd111);
    check_eq("n27_rec", m_rec, 32'd9232);

    run(0, 32'd1, edges, bcnt);
    check_eq("n1_edges", edges, 2);
    check_eq("n1_len", m_len, 16'd0);
    check_eq("n1_rec", m_rec, 32'd1);

    run(1, 32'd255, edges, bcnt);
    check_eq("b255_edges", edges, 2);
    check_eq("b255_status", m_status, 2'b01);
    check_eq("b255_len", m_len, 16'd0);
    check_eq("b255_rec", m_rec, 32'd255);

    run(1, 32'd7, edges, bcnt);
    check_eq("b7_status", m_status, 2'b00);
    check_eq("b7_len", m_len, 16'd16);
    check_eq("b7_rec", m_rec, 32'd52);

    run(2, 32'd27, edges, bcnt);
    check_eq("lim_edges", edges, 12);
    check_eq("lim_status", m_status, 2'b10);
    check_eq("lim_len", m_len, 16'd10);
    check_eq("lim_rec", m_rec, 32'd214);

    run(2, 32'd0, edges, bcnt);
    check_eq("zero_edges", edges, 1);
    check_eq("zero_status", m_status, 2'b11);
    check_eq("zero_len", m_len, 16'd0);
    check_eq("zero_rec", m_rec, 32'd0);

    // Abort after four steps with start held high throughout RUN
    sel = 0;
    @(negedge clk);
    a_start = 1'b1; a_number = 32'd27;
    repeat (5) @(posedge clk);
    @(negedge clk);
    a_start = 1'b0; a_abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_abort = 1'b0;
    check_eq("abort_busy", a_busy, 1'b0);
    check_eq("abort_len", a_len, 16'd4);
    check_eq("abort_rec", a_rec, 32'd124);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (a_done || a_busy) done_seen++;
      @(negedge clk);
    end
    check_eq("abort_quiet", done_seen, 0);

    // Asynchronous reset between clock edges while running
    @(negedge clk);
    a_start = 1'b1; a_number = 32'd27;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", a_busy, 1'b0);
    check_eq("arst_done", a_done, 1'b0);
    check_eq("arst_status", a_status, 2'd0);
    check_eq("arst_len", a_len, 16'd0);
    check_eq("arst_rec", a_rec, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 32'd6, edges, bcnt);
    check_eq("post_edges", edges, 10);
    check_eq("post_status", m_status, 2'b00);
    check_eq("post_len", m_len, 16'd8);
    check_eq("post_rec", m_rec, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
